// File: rtl/axis_pattern_gen.sv
// AXI4-Stream test-pattern source: configurable width, byte-exact packet length,
// packet count, inter-packet gap and four data pattern modes.
module axis_pattern_gen #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic                start,
    input  logic                stop,
    input  logic [1:0]          mode,
    input  logic [LEN_W-1:0]    pkt_bytes,
    input  logic [CNT_W-1:0]    pkt_count,
    input  logic [CNT_W-1:0]    gap_cycles,
    input  logic [31:0]         seed,
    output logic [DATA_W-1:0]   tdata,
    output logic [DATA_W/8-1:0] tkeep,
    output logic                tlast,
    output logic                tvalid,
    input  logic                tready,
    output logic                busy,
    output logic                done,
    output logic                cfg_err,
    output logic [CNT_W-1:0]    pkts_sent
);

    localparam int BYTES = DATA_W / 8;
    localparam int LANES = DATA_W / 32;
    localparam int BLOG  = $clog2(BYTES);
    localparam int WLOG  = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t             state, state_nxt;
    logic [1:0]         cfg_mode;
    logic [LEN_W-1:0]   cfg_bytes;
    logic [CNT_W-1:0]   cfg_count;
    logic [CNT_W-1:0]   cfg_gap;
    logic [31:0]        cfg_seed;
    logic [31:0]        ctr;
    logic [31:0]        lfsr;
    logic [DATA_W-1:0]  walk;
    logic [LEN_W-1:0]   beat_cnt;
    logic [LEN_W-1:0]   last_beat;
    logic [CNT_W-1:0]   gap_cnt;
    logic [CNT_W-1:0]   pkts_nxt;
    logic [BLOG-1:0]    rem;
    logic               stop_seen;
    logic               stop_now;
    logic               is_last;
    logic               xfer;
    logic               pkt_end;
    logic               accept;
    logic               reject;

    assign last_beat = LEN_W'((cfg_bytes - LEN_W'(1)) >> BLOG);
    assign rem       = cfg_bytes[BLOG-1:0];
    assign is_last   = (beat_cnt == last_beat);
    assign xfer      = (state == SEND) && tready;
    assign pkt_end   = xfer && is_last;
    assign accept    = (state == IDLE) && start && (pkt_bytes != '0);
    assign reject    = (state == IDLE) && start && (pkt_bytes == '0);
    assign stop_now  = stop_seen || stop;
    assign pkts_nxt  = pkts_sent + CNT_W'(1);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = SEND;
            SEND: begin
                if (pkt_end) begin
                    if (stop_now || ((cfg_count != '0) && (pkts_nxt == cfg_count)))
                        state_nxt = DONE;
                    else if (cfg_gap != '0)
                        state_nxt = GAP;
                    else
                        state_nxt = SEND;
                end
            end
            GAP: begin
                if (stop_now)            state_nxt = DONE;
                else if (gap_cnt == '0)  state_nxt = SEND;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cfg_mode  <= '0;
            cfg_bytes <= '0;
            cfg_count <= '0;
            cfg_gap   <= '0;
            cfg_seed  <= '0;
            ctr       <= '0;
            lfsr      <= '0;
            walk      <= '0;
            beat_cnt  <= '0;
            gap_cnt   <= '0;
            pkts_sent <= '0;
            stop_seen <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= reject;
            if (accept) begin
                cfg_mode  <= mode;
                cfg_bytes <= pkt_bytes;
                cfg_count <= pkt_count;
                cfg_gap   <= gap_cycles;
                cfg_seed  <= seed;
                ctr       <= seed;
                lfsr      <= (seed == '0) ? 32'd1 : seed;
                walk      <= DATA_W'(1) << seed[WLOG-1:0];
                beat_cnt  <= '0;
                pkts_sent <= '0;
                stop_seen <= 1'b0;
            end else if (stop && (state != IDLE)) begin
                stop_seen <= 1'b1;
            end
            // All pattern generators step together; the mode only selects the output.
            if (xfer) begin
                ctr      <= ctr + 32'(LANES);
                lfsr     <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
                walk     <= {walk[DATA_W-2:0], walk[DATA_W-1]};
                beat_cnt <= is_last ? '0 : beat_cnt + LEN_W'(1);
                if (is_last) begin
                    pkts_sent <= pkts_nxt;
                    gap_cnt   <= cfg_gap - CNT_W'(1);
                end
            end
            if ((state == GAP) && (gap_cnt != '0))
                gap_cnt <= gap_cnt - CNT_W'(1);
        end
    end

    always_comb begin
        tvalid = (state == SEND);
        busy   = (state != IDLE);
        done   = (state == DONE);
        tlast  = tvalid && is_last;
        tkeep  = '0;
        tdata  = '0;
        if (tvalid) begin
            for (int unsigned b = 0; b < BYTES; b++)
                tkeep[b] = !(is_last && (rem != '0)) || (BLOG'(b) < rem);
            case (cfg_mode)
                2'd0: for (int unsigned i = 0; i < LANES; i++) tdata[32*i +: 32] = ctr + 32'(i);
                2'd1: for (int unsigned i = 0; i < LANES; i++) tdata[32*i +: 32] = lfsr ^ 32'(i);
                2'd2: for (int unsigned i = 0; i < LANES; i++) tdata[32*i +: 32] = cfg_seed;
                default: tdata = walk;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Self-checking bench for axis_pattern_gen (64-bit instance) against a beat-list reference model.
module tb_axis_pattern_gen;

    localparam int DW = 64;
    localparam int LW = 16;
    localparam int CW = 32;
    localparam int BY = DW / 8;
    localparam int LN = DW / 32;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          tready = 1'b0;
    logic [1:0]    mode = '0;
    logic [LW-1:0] pkt_bytes = '0;
    logic [CW-1:0] pkt_count = '0;
    logic [CW-1:0] gap_cycles = '0;
    logic [31:0]   seed = '0;
    logic [DW-1:0] tdata;
    logic [BY-1:0] tkeep;
    logic          tlast, tvalid, busy, done, cfg_err;
    logic [CW-1:0] pkts_sent;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic [BY-1:0] keep;
        logic          last;
        int            stamp;
    } beat_t;

    beat_t got[$];
    beat_t exp_q[$];

    axis_pattern_gen #(.DATA_W(DW), .LEN_W(LW), .CNT_W(CW)) dut (
        .clk(clk), .aresetn(aresetn), .start(start), .stop(stop), .mode(mode),
        .pkt_bytes(pkt_bytes), .pkt_count(pkt_count), .gap_cycles(gap_cycles), .seed(seed),
        .tdata(tdata), .tkeep(tkeep), .tlast(tlast), .tvalid(tvalid), .tready(tready),
        .busy(busy), .done(done), .cfg_err(cfg_err), .pkts_sent(pkts_sent)
    );

    always #5 clk = ~clk;

    // Reference: the whole run as a list of beats, from the pattern rules directly.
    task automatic build_exp(input logic [1:0] m, input logic [31:0] s, input int bytes, input int npk);
        int nb;
        int k;
        int pos;
        logic [31:0] lf;
        beat_t e;
        nb = (bytes + BY - 1) / BY;
        k = 0;
        lf = (s == 32'd0) ? 32'd1 : s;
        exp_q.delete();
        for (int p = 0; p < npk; p++) begin
            for (int j = 0; j < nb; j++) begin
                e.data = '0;
                for (int l = 0; l < LN; l++) begin
                    case (m)
                        2'd0: e.data[32*l +: 32] = s + 32'(k * LN + l);
                        2'd1: e.data[32*l +: 32] = lf ^ 32'(l);
                        2'd2: e.data[32*l +: 32] = s;
                        default: ;
                    endcase
                end
                if (m == 2'd3) begin
                    pos = (int'(s % 32'(DW)) + k) % DW;
                    e.data[pos] = 1'b1;
                end
                e.last = (j == nb - 1);
                e.keep = (e.last && (bytes % BY) != 0) ? BY'((1 << (bytes % BY)) - 1) : '1;
                e.stamp = 0;
                exp_q.push_back(e);
                k++;
                lf = lf[0] ? ((lf >> 1) ^ 32'h8020_0003) : (lf >> 1);
            end
        end
    endtask

    function automatic string diff_beats();
        int n;
        logic [DW-1:0] msk;
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            msk = '0;
            for (int b = 0; b < BY; b++) if (exp_q[i].keep[b]) msk[8*b +: 8] = 8'hFF;
            if (got[i].keep !== exp_q[i].keep || got[i].last !== exp_q[i].last ||
                (got[i].data & msk) !== (exp_q[i].data & msk))
                return $sformatf("beat %0d got %h/%h/%b required %h/%h/%b", i,
                                 got[i].data, got[i].keep, got[i].last,
                                 exp_q[i].data, exp_q[i].keep, exp_q[i].last);
        end
        if (got.size() != exp_q.size())
            return $sformatf("beat count got %0d required %0d", got.size(), exp_q.size());
        return "";
    endfunction

    task automatic go(input logic [1:0] m, input logic [31:0] s, input int b, input int n,
                      input int g, input bit rdy);
        @(posedge clk); #1;
        mode = m; seed = s; pkt_bytes = LW'(b); pkt_count = CW'(n); gap_cycles = CW'(g);
        tready = rdy; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Collects transfers until done, checking output stability under backpressure.
    task automatic run(input int budget, input bit rnd, input int stop_at, input bit poke,
                       output int dones, output int errs);
        bit stalled;
        bit stop_sent;
        beat_t prev, cur;
        stalled = 0; stop_sent = 0; dones = 0; errs = 0;
        got.delete();
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            cur.data = tdata; cur.keep = tkeep; cur.last = tlast; cur.stamp = c;
            if (stalled) begin
                total++;
                if (tvalid !== 1'b1 || cur.data !== prev.data || cur.keep !== prev.keep || cur.last !== prev.last) begin
                    bad++;
                    $display("FAIL stall_stable: cycle %0d got v=%b %h/%h/%b required v=1 %h/%h/%b",
                             c, tvalid, cur.data, cur.keep, cur.last, prev.data, prev.keep, prev.last);
                end
            end
            stalled = tvalid && !tready;
            prev = cur;
            if (tvalid && tready) got.push_back(cur);
            if (cfg_err) errs++;
            if (done) begin
                dones++;
                break;
            end
            @(posedge clk); #1;
            stop = 1'b0; start = 1'b0;
            if (stop_at >= 0 && !stop_sent && got.size() == stop_at) begin
                stop = 1'b1; stop_sent = 1;
            end
            if (poke && c == 2) begin start = 1'b1; pkt_bytes = '0; mode = 2'd2; end
            if (poke && c == 3) begin start = 1'b1; pkt_bytes = LW'(8); seed = 32'hDEAD_BEEF; end
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        stop = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got v=%b l=%b busy=%b done=%b err=%b required all 0",
                     tvalid, tlast, busy, done, cfg_err);
        end
        total++;
        if (tdata !== '0 || tkeep !== '0 || pkts_sent !== '0) begin
            bad++;
            $display("FAIL reset_data: got %h/%h/%0d required 0/0/0", tdata, tkeep, pkts_sent);
        end
        @(posedge clk); #1;
        aresetn = 1'b1;
    endtask

    task automatic test_counter();
        int d, e;
        string s;
        go(2'd0, 32'd0, 16, 2, 0, 1'b1);
        run(200, 1'b0, -1, 1'b0, d, e);
        build_exp(2'd0, 32'd0, 16, 2);
        s = diff_beats();
        total++;
        if (s != "") begin bad++; $display("FAIL counter_beats: %s", s); end
        total++;
        if (got.size() < 3 || got[2].stamp - got[1].stamp != 1) begin
            bad++;
            $display("FAIL counter_no_bubble: got stamp gap %0d required 1", got[2].stamp - got[1].stamp);
        end
        total++;
        if (d != 1 || pkts_sent !== 32'd2) begin
            bad++;
            $display("FAIL counter_done: got done=%0d pkts=%0d required 1/2", d, pkts_sent);
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL counter_idle: got busy=%b done=%b required 0/0", busy, done);
        end
    endtask

    task automatic test_partial_const();
        int d, e;
        string s;
        go(2'd2, 32'hA5A5_A5A5, 13, 1, 0, 1'b1);
        run(200, 1'b0, -1, 1'b0, d, e);
        build_exp(2'd2, 32'hA5A5_A5A5, 13, 1);
        s = diff_beats();
        total++;
        if (s != "") begin bad++; $display("FAIL partial_beats: %s", s); end
        total++;
        if (d != 1 || pkts_sent !== 32'd1) begin
            bad++;
            $display("FAIL partial_done: got done=%0d pkts=%0d required 1/1", d, pkts_sent);
        end
    endtask

    task automatic test_lfsr_backpressure();
        int d, e, b, n;
        logic [1:0] m;
        logic [31:0] sd;
        string s;
        go(2'd1, 32'd1, 64, 3, 0, 1'($urandom_range(0, 1)));
        run(2000, 1'b1, -1, 1'b0, d, e);
        build_exp(2'd1, 32'd1, 64, 3);
        s = diff_beats();
        total++;
        if (s != "") begin bad++; $display("FAIL lfsr_beats: %s", s); end
        total++;
        if (d != 1 || pkts_sent !== 32'd3) begin
            bad++;
            $display("FAIL lfsr_done: got done=%0d pkts=%0d required 1/3", d, pkts_sent);
        end
        for (int it = 0; it < 5; it++) begin
            m = 2'($urandom_range(0, 3));
            sd = (it == 0) ? 32'hFFFF_FFFE : $urandom;
            if (it == 1) sd = 32'd0;
            b = $urandom_range(1, 40);
            n = $urandom_range(1, 3);
            go(m, sd, b, n, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            run(1000, 1'b1, -1, 1'b0, d, e);
            build_exp(m, sd, b, n);
            s = diff_beats();
            total++;
            if (s != "" || pkts_sent !== CW'(n)) begin
                bad++;
                $display("FAIL random_run%0d: mode=%0d bytes=%0d pkts=%0d(req %0d) %s", it, m, b, pkts_sent, n, s);
            end
        end
    endtask

    task automatic test_stop_gap();
        int d, e;
        string s;
        logic [31:0] sd;
        sd = $urandom;
        go(2'd0, sd, 32, 0, 5, 1'b1);
        run(500, 1'b0, 5, 1'b0, d, e);
        build_exp(2'd0, sd, 32, 2);
        s = diff_beats();
        total++;
        if (s != "") begin bad++; $display("FAIL stop_beats: %s", s); end
        total++;
        if (got.size() < 5 || got[4].stamp - got[3].stamp != 6) begin
            bad++;
            $display("FAIL stop_gap_len: got idle %0d required 5", got[4].stamp - got[3].stamp - 1);
        end
        total++;
        if (d != 1 || pkts_sent !== 32'd2) begin
            bad++;
            $display("FAIL stop_done: got done=%0d pkts=%0d required 1/2", d, pkts_sent);
        end
    endtask

    task automatic test_cfg_err();
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        pkt_bytes = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || tvalid !== 1'b0) begin
            bad++;
            $display("FAIL cfg_err_pulse: got err=%b busy=%b v=%b required 1/0/0", cfg_err, busy, tvalid);
        end
        @(posedge clk); #1;
        total++;
        if (cfg_err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL cfg_err_clear: got err=%b busy=%b required 0/0", cfg_err, busy);
        end
    endtask

    task automatic test_start_busy();
        int d, e;
        string s;
        go(2'd0, 32'd100, 24, 2, 2, 1'b1);
        run(500, 1'b0, -1, 1'b1, d, e);
        build_exp(2'd0, 32'd100, 24, 2);
        s = diff_beats();
        total++;
        if (s != "") begin bad++; $display("FAIL busy_start_beats: %s", s); end
        total++;
        if (d != 1 || e != 0 || pkts_sent !== 32'd2) begin
            bad++;
            $display("FAIL busy_start_ctrl: got done=%0d err=%0d pkts=%0d required 1/0/2", d, e, pkts_sent);
        end
    endtask

    task automatic test_reset_mid();
        int d, e;
        string s;
        logic [31:0] sd;
        sd = $urandom;
        go(2'd0, sd, 32, 1, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (tvalid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b required 1", tvalid); end
        @(posedge clk); #3;
        aresetn = 1'b0;
        #1;
        total++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || busy !== 1'b0 || tdata !== '0) begin
            bad++;
            $display("FAIL mid_reset: got v=%b l=%b busy=%b d=%h required 0/0/0/0", tvalid, tlast, busy, tdata);
        end
        @(posedge clk); #1;
        aresetn = 1'b1;
        go(2'd0, sd, 32, 1, 0, 1'b1);
        run(200, 1'b0, -1, 1'b0, d, e);
        build_exp(2'd0, sd, 32, 1);
        s = diff_beats();
        total++;
        if (s != "" || pkts_sent !== 32'd1) begin
            bad++;
            $display("FAIL post_reset_run: pkts=%0d required 1 %s", pkts_sent, s);
        end
    endtask

    initial begin
        test_reset();
        test_counter();
        test_partial_const();
        test_lfsr_backpressure();
        test_stop_gap();
        test_cfg_err();
        test_start_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_pattern_gen.md
Name: axis_pattern_gen

Overview:
Parametrised AXI4-Stream test-pattern source. It is the successor to the fixed 32-bit stream generator that feeds the DMA S2MM port in the Zynq system.
- Adds configurable data width, byte-exact packet length with a partial last beat, packet count, inter-packet gap and four pattern modes.
- Runs on the PL AXI clock; configured from PS-driven GPIO/register bits.

Parameters:
DATA_W, 32, tdata width in bits; legal values 32, 64, 128.
LEN_W, 16, width of pkt_bytes.
CNT_W, 32, width of pkt_count, gap_cycles, pkts_sent.

Ports:
clk  input  1  stream clock (axi_aclk)
aresetn  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; latches config and begins a run
stop  input  1  one-cycle pulse; ends the run after the current packet
mode  input  2  0=incrementing counter, 1=LFSR, 2=constant seed, 3=walking one
pkt_bytes  input  LEN_W  bytes per packet, must be >=1
pkt_count  input  CNT_W  packets per run; 0 = run until stop
gap_cycles  input  CNT_W  idle cycles between packets
seed  input  32  initial counter/LFSR value, or constant value
tdata  output  DATA_W  stream data
tkeep  output  DATA_W/8  byte enables
tlast  output  1  last beat of packet
tvalid  output  1  stream valid
tready  input  1  stream ready
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse when a run completes
cfg_err  output  1  one-cycle pulse when start is rejected
pkts_sent  output  CNT_W  packets completed in the current run; cleared on accepted start

Behaviour:
- Reset (async assert, sync release): state IDLE. tvalid, tlast, busy, done and cfg_err are 0; tdata, tkeep and pkts_sent are 0; pattern registers are 0.
- Parameters: BYTES = DATA_W/8; LANES = DATA_W/32.
- Beats per packet = ceil(pkt_bytes/BYTES). The last beat has tkeep low (pkt_bytes mod BYTES) bits set, or all ones if the remainder is 0. All other beats have tkeep all ones.
- FSM states: IDLE, SEND, GAP, DONE.
  - IDLE, start with pkt_bytes==0: cfg_err pulses next cycle; remain in IDLE.
  - IDLE, valid start: latch mode, pkt_bytes, pkt_count, gap_cycles and seed; load pattern state from seed; clear pkts_sent; go to SEND. tvalid rises in the cycle after start.
  - SEND: tvalid=1. A beat transfers when tvalid&&tready. tdata, tkeep and tlast stay stable while tvalid&&!tready.
  - SEND, on the tlast transfer: pkts_sent++. Then:
    - if stop has been seen, or pkts_sent reaches a nonzero pkt_count, go to DONE;
    - otherwise, if gap_cycles>0, go to GAP;
    - otherwise go to SEND, and the next packet's first beat follows with no bubble.
  - GAP: tvalid=0 for exactly gap_cycles cycles, then SEND. A stop seen during GAP goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- stop handling: stop is latched into a sticky flag and cleared on an accepted start. A packet is never truncated; it always ends with tlast. Stop in IDLE is ignored.
- start while busy is ignored. cfg_err is not asserted.
- Pattern (the pattern advances only on a transfer):
  - mode 0: lane i = counter+i, 32-bit wrap; counter += LANES per beat. Continues across packets within a run; 0xFFFFFFFF wraps to 0.
  - mode 1: 32-bit Galois LFSR with polynomial 0x80200003, advanced once per beat. Lane i = lfsr XOR i. seed==0 is replaced by 1.
  - mode 2: every lane = seed.
  - mode 3: a one-hot DATA_W-bit vector rotated left one bit per beat; initial bit = seed mod DATA_W.
- Pattern values do not reset between packets. Byte lanes with tkeep=0 still carry pattern data; verification must not check them.
- Reset asserted mid-packet drops tvalid immediately with no tlast. Behaviour after reset release is that of a fresh IDLE.
- No combinational path from tready to any output.

Test Plan:
- DATA_W=32, mode 0, seed=0, pkt_bytes=16, pkt_count=2, gap=0, tready=1 -> 8 beats with tdata 0..7, tlast on beats 4 and 8, tkeep=0xF, done pulse, pkts_sent=2.
- DATA_W=64, pkt_bytes=13, pkt_count=1, mode 2, seed=0xA5A5A5A5 -> 2 beats, tkeep 0xFF then 0x1F, tlast on beat 2, tdata=0xA5A5A5A5A5A5A5A5.
- Random tready (50%), mode 1, seed=1, pkt_bytes=64, pkt_count=3 -> 48 beats matching the reference LFSR sequence; outputs stable whenever tvalid&&!tready.
- pkt_count=0, gap_cycles=5, stop pulsed mid-packet 2 -> packet 2 completes with tlast; tvalid low for exactly 5 cycles between packets 1 and 2; done pulses after packet 2; pkts_sent=2.
- start with pkt_bytes=0 -> cfg_err pulse, busy stays 0. start while busy -> no effect.
- aresetn asserted during SEND with tready=0 -> tvalid=0 immediately. Fresh start after release -> mode 0 pattern restarts from seed.
